// File: rtl/bayer_pkg.sv
// Shared encodings for the Bayer test-pattern source: FSM states, pattern selects,
// Bayer phase codes and the 12-bit flat-colour levels.
package bayer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_FLAT    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_ZERO    = 2'd3
    } pat_t;

    // Phase index is {line parity, column parity}
    localparam logic [1:0] PH_R  = 2'b00;
    localparam logic [1:0] PH_GR = 2'b01;
    localparam logic [1:0] PH_GB = 2'b10;
    localparam logic [1:0] PH_B  = 2'b11;

    localparam logic [11:0] FLAT_R = 12'hC00;
    localparam logic [11:0] FLAT_G = 12'h800;
    localparam logic [11:0] FLAT_B = 12'h400;

    function automatic logic [11:0] flat_colour(input logic [1:0] phase);
        logic [11:0] c;
        case (phase)
            PH_R:    c = FLAT_R;
            PH_B:    c = FLAT_B;
            default: c = FLAT_G;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bayer_src_gen_if.sv
// Bayer stream bundle: run controls into the source, pixel/framing outputs from it.
// No handshake; the sink samples every mclk cycle.
interface bayer_src_gen_if #(
    parameter int DATA_W = 12
);
    logic              en;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] pix_data;
    logic              href;
    logic              vsync;
    logic [11:0]       pixcnt;
    logic              frame_start;
    logic              busy;

    modport master (
        input  en, pattern_sel,
        output pix_data, href, vsync, pixcnt, frame_start, busy
    );

    modport slave (
        output en, pattern_sel,
        input  pix_data, href, vsync, pixcnt, frame_start, busy
    );
endinterface

// File: rtl/bayer_src_gen_raster_cnt.sv
// Column/line position counters with wrap and an end-of-frame flag on the last raster cycle.
// Latency: counters update on the edge after adv; clr has priority and holds them at zero.
module raster_cnt #(
    parameter int H_TOT = 1440,
    parameter int V_TOT = 750,
    parameter int HW    = 11,
    parameter int VW    = 10
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          eof
);
    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == HW'(H_TOT - 1));
    assign v_last = (v_cnt == VW'(V_TOT - 1));
    assign eof    = h_last && v_last;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (adv) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/bayer_src_gen.sv
// Bayer test-pattern raster source standing in for the sensor front end of bayer2rgb.
// Latency: all outputs registered one cycle behind the raster position; free-running, no backpressure.
module bayer_src_gen
    import bayer_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 720,
    parameter int V_BLANK  = 30,
    parameter int VS_W     = 2,
    parameter int STARTUP  = 128,
    parameter int DATA_W   = 12
) (
    input  logic             mclk,
    input  logic             rst_n,
    bayer_src_gen_if.master  bus
);
    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int V_TOT = V_ACTIVE + V_BLANK;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SW    = (STARTUP > 1) ? $clog2(STARTUP) : 1;
    localparam int SH_L  = (DATA_W > 12) ? DATA_W - 12 : 0;
    localparam int SH_R  = (DATA_W < 12) ? 12 - DATA_W : 0;

    state_t            state;
    state_t            state_nxt;
    logic [SW-1:0]     st_cnt;
    logic              st_done;
    logic              raster_on;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              eof;
    pat_t              pat_reg;
    pat_t              pat_cur;
    logic              frame_first;
    logic              active;
    logic              vs_line;
    logic [1:0]        phase;
    logic              chk_bit;
    logic [DATA_W-1:0] pix_nxt;

    assign st_done   = (st_cnt == SW'(STARTUP - 1));
    assign raster_on = (state == ST_RUN) || (state == ST_DRAIN);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Stopping only ever happens on the last raster cycle, so frames are never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.en) state_nxt = ST_STARTUP;
            ST_STARTUP: begin
                if (!bus.en)      state_nxt = ST_IDLE;
                else if (st_done) state_nxt = ST_RUN;
            end
            ST_RUN:     if (!bus.en) state_nxt = eof ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (bus.en)  state_nxt = ST_RUN;
                else if (eof) state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)                    st_cnt <= '0;
        else if (state == ST_STARTUP)  st_cnt <= st_cnt + SW'(1);
        else                           st_cnt <= '0;
    end

    raster_cnt #(
        .H_TOT (H_TOT),
        .V_TOT (V_TOT),
        .HW    (HW),
        .VW    (VW)
    ) u_raster (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (!raster_on),
        .adv   (raster_on),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .eof   (eof)
    );

    // Pattern is latched at the first pixel of the frame and applies to that pixel already.
    assign frame_first = raster_on && (h_cnt == '0) && (v_cnt == '0);
    assign pat_cur     = frame_first ? pat_t'(bus.pattern_sel) : pat_reg;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)           pat_reg <= PAT_FLAT;
        else if (frame_first) pat_reg <= pat_cur;
    end

    assign active  = raster_on && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign vs_line = raster_on && (32'(v_cnt) >= V_ACTIVE) && (32'(v_cnt) < V_ACTIVE + VS_W);
    assign phase   = {v_cnt[0], h_cnt[0]};
    assign chk_bit = 1'(32'(h_cnt) >> 3) ^ 1'(32'(v_cnt) >> 3);

    always_comb begin
        pix_nxt = '0;
        if (active) begin
            case (pat_cur)
                PAT_FLAT:    pix_nxt = DATA_W'((32'(flat_colour(phase)) << SH_L) >> SH_R);
                PAT_RAMP:    pix_nxt = DATA_W'(h_cnt);
                PAT_CHECKER: pix_nxt = {DATA_W{chk_bit}};
                default:     pix_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_data    <= '0;
            bus.href        <= 1'b0;
            bus.vsync       <= 1'b0;
            bus.pixcnt      <= '0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.pix_data    <= pix_nxt;
            bus.href        <= active;
            bus.vsync       <= vs_line;
            bus.pixcnt      <= active ? 12'(h_cnt) : 12'd0;
            bus.frame_start <= frame_first;
            bus.busy        <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bayer_src_gen.sv
// Randomised scoreboard bench for bayer_src_gen against a frame-position reference model.
module tb_bayer_src_gen;
    localparam int HA    = 8;
    localparam int HB    = 4;
    localparam int VA    = 4;
    localparam int VB    = 3;
    localparam int VS    = 2;
    localparam int ST    = 10;
    localparam int DW    = 12;
    localparam int H_TOT = HA + HB;
    localparam int V_TOT = VA + VB;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct {
        int pix;
        int pixcnt;
        bit href;
        bit vsync;
        bit fs;
        bit busy;
    } exp_t;

    logic mclk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    bayer_src_gen_if #(.DATA_W(DW)) bus ();

    bayer_src_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .VS_W     (VS),
        .STARTUP  (ST),
        .DATA_W   (DW)
    ) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
        end
    endtask

    function automatic int exp_pix(input int pat, input int h, input int v);
        case (pat)
            0: begin
                if (v % 2 == 0 && h % 2 == 0) return 'hC00;
                if (v % 2 == 1 && h % 2 == 1) return 'h400;
                return 'h800;
            end
            1: return h % 4096;
            2: return (((h / 8) + (v / 8)) % 2 == 1) ? 'hFFF : 0;
            default: return 0;
        endcase
    endfunction

    // Reference: idle -> ST-cycle hold -> frames indexed by position; stops only at frame end with en low.
    exp_t exp_q[$];
    int   m_mode;
    int   m_wait;
    int   m_pos;
    int   m_pat;
    int   m_h;
    int   m_v;
    exp_t m_e;

    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_wait = 0;
            m_pos  = 0;
            exp_q.delete();
        end else begin
            m_e.pix = 0; m_e.pixcnt = 0; m_e.href = 0; m_e.vsync = 0; m_e.fs = 0;
            m_e.busy = (m_mode != 0);
            if (m_mode == 2) begin
                m_h = m_pos % H_TOT;
                m_v = m_pos / H_TOT;
                if (m_pos == 0) m_pat = int'(bus.pattern_sel);
                m_e.href   = (m_h < HA) && (m_v < VA);
                m_e.vsync  = (m_v >= VA) && (m_v < VA + VS);
                m_e.fs     = (m_pos == 0);
                m_e.pixcnt = m_e.href ? m_h : 0;
                m_e.pix    = m_e.href ? exp_pix(m_pat, m_h, m_v) : 0;
            end
            exp_q.push_back(m_e);
            case (m_mode)
                0: if (bus.en) begin m_mode = 1; m_wait = ST; end
                1: begin
                    if (!bus.en) m_mode = 0;
                    else begin
                        m_wait--;
                        if (m_wait == 0) begin m_mode = 2; m_pos = 0; end
                    end
                end
                default: begin
                    if (m_pos == FRAME - 1 && !bus.en) m_mode = 0;
                    else m_pos = (m_pos + 1) % FRAME;
                end
            endcase
        end
    end

    // Monitor: per-cycle scoreboard compare plus frame-level timing checks
    exp_t got;
    bit   fs_ok;
    bit   vs_prev;
    int   fs_cyc;
    int   vs_cyc;
    int   href_n;

    always @(negedge mclk) begin
        if (!rst_n) begin
            fs_ok   = 0;
            vs_prev = 0;
        end else begin
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk("href",        int'(bus.href),        int'(got.href));
                chk("vsync",       int'(bus.vsync),       int'(got.vsync));
                chk("frame_start", int'(bus.frame_start), int'(got.fs));
                chk("busy",        int'(bus.busy),        int'(got.busy));
                chk("pixcnt",      int'(bus.pixcnt),      got.pixcnt);
                chk("pix_data",    int'(bus.pix_data),    got.pix);
            end
            if (!bus.busy) fs_ok = 0;
            if (bus.frame_start) begin
                if (fs_ok) begin
                    chk("frame_period", cyc - fs_cyc, FRAME);
                    chk("href_per_frame", href_n, HA * VA);
                end
                fs_ok  = 1;
                fs_cyc = cyc;
                href_n = 0;
            end
            if (bus.href) href_n++;
            if (fs_ok && bus.vsync && !vs_prev) begin
                chk("vsync_offset", cyc - fs_cyc, VA * H_TOT);
                vs_cyc = cyc;
            end
            if (fs_ok && !bus.vsync && vs_prev) chk("vsync_len", cyc - vs_cyc, VS * H_TOT);
            vs_prev = bus.vsync;
        end
    end

    // Call at the negedge where en first goes high; counts edges until the first href.
    task automatic check_startup();
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge mclk);
            n++;
            @(negedge mclk);
            if (bus.href) seen = 1;
        end
        chk("startup_latency", n, ST + 2);
        chk("startup_fs", int'(bus.frame_start), 1);
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!bus.frame_start && n < budget);
        chk("wait_frame_start", int'(bus.frame_start), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_href"},  int'(bus.href),        0);
        chk({tag, "_vsync"}, int'(bus.vsync),       0);
        chk({tag, "_fs"},    int'(bus.frame_start), 0);
        chk({tag, "_busy"},  int'(bus.busy),        0);
        chk({tag, "_pixcnt"}, int'(bus.pixcnt),     0);
        chk({tag, "_pix"},   int'(bus.pix_data),    0);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        m_pat = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.pattern_sel = 2'd0;
        repeat (3) @(negedge mclk);
        check_zero("reset");

        rst_n  = 1'b1;
        bus.en = 1'b1;
        check_startup();

        // Switch to ramp mid-frame; current frame must stay flat
        repeat (30) @(negedge mclk);
        bus.pattern_sel = 2'd1;
        wait_fs(200);

        // Drop en in active line 2 and let the frame drain
        repeat (26) @(negedge mclk);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge mclk);
            n++;
        end
        chk("drain_busy_fall", int'(bus.busy), 0);
        repeat (20) @(negedge mclk);
        check_zero("idle");

        bus.en = 1'b1;
        bus.pattern_sel = 2'd2;
        check_startup();

        // en re-raised during drain: raster must not break
        wait_fs(200);
        repeat (30) @(negedge mclk);
        bus.en = 1'b0;
        repeat (10) @(negedge mclk);
        bus.en = 1'b1;
        repeat (2 * FRAME) @(negedge mclk);

        for (int i = 0; i < 1500; i++) begin
            @(negedge mclk);
            bus.pattern_sel = 2'($urandom_range(0, 3));
            if (bus.en) begin
                if ($urandom_range(0, 99) < 3) bus.en = 1'b0;
            end else if ($urandom_range(0, 99) < 20) begin
                bus.en = 1'b1;
            end
        end

        // Reset pulse in the middle of an active line
        bus.en = 1'b1;
        bus.pattern_sel = 2'd2;
        n = 0;
        while (!bus.href && n < 300) begin
            @(negedge mclk);
            n++;
        end
        chk("pre_reset_href", int'(bus.href), 1);
        @(posedge mclk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (3) @(negedge mclk);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        check_startup();
        repeat (100) @(negedge mclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
